// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes, status flags, shifts/compares
// and an iterative shift-add multiplier / restoring divider (one transaction in flight).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for MUL/DIVU/REMU; results held until OUT_READY.

module alu_seq #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_OPERATION,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_RESULT,
  output logic [WIDTH-1:0] ALU_RESULT_HI,
  output logic             ZERO,
  output logic             NEG,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             ILLEGAL
);

  localparam int            SW   = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;      // multiplicand / divisor
  logic [WIDTH-1:0] acc_q;    // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier -> product low half / dividend -> quotient
  logic [SW-1:0]    cnt_q;
  logic             in_rdy_q;
  logic             out_vld_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q, neg_q, carry_q, ovf_q, ill_q;

  // single-cycle datapath, evaluated on the live inputs at the accepting edge
  logic [WIDTH:0]   add_w, sub_w;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sc_res_d;
  logic             sc_carry_d, sc_ovf_d, sc_ill_d, sc_iter_d;

  // iterative datapath
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] acc_d, lo_d, fin_res_d, fin_hi_d;

  // Decode the opcode and compute every single-cycle result and its flags
  always_comb begin
    add_w      = {1'b0, A} + {1'b0, B};
    sub_w      = {1'b0, A} - {1'b0, B};   // bit WIDTH is the unsigned borrow
    shamt      = B[SW-1:0];
    sc_res_d   = '0;
    sc_carry_d = 1'b0;
    sc_ovf_d   = 1'b0;
    sc_ill_d   = 1'b0;
    sc_iter_d  = 1'b0;
    case (ALU_OPERATION)
      OP_AND:  sc_res_d = A & B;
      OP_OR:   sc_res_d = A | B;
      OP_XOR:  sc_res_d = A ^ B;
      OP_ADD: begin
        sc_res_d   = add_w[WIDTH-1:0];
        sc_carry_d = add_w[WIDTH];
        sc_ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_d   = sub_w[WIDTH-1:0];
        sc_carry_d = sub_w[WIDTH];
        sc_ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res_d = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  sc_res_d = A << shamt;
      OP_SRL:  sc_res_d = A >> shamt;
      OP_SRA:  sc_res_d = $signed(A) >>> shamt;
      OP_MUL, OP_DIVU, OP_REMU: begin
        if (MULDIV_EN) begin
          sc_iter_d = 1'b1;
        end else begin
          sc_res_d = '1;
          sc_ill_d = 1'b1;
        end
      end
      default: begin
        sc_res_d = '1;
        sc_ill_d = 1'b1;
      end
    endcase
  end

  // One shift-add multiply step or one restoring-divide step per BUSY cycle
  always_comb begin
    mul_add   = lo_q[0] ? b_q : '0;
    mul_sum   = {1'b0, acc_q} + {1'b0, mul_add};
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    // the true difference is below 2^WIDTH whenever div_ge holds, so the low bits suffice
    div_sub   = div_shift[WIDTH-1:0] - b_q;
    if (op_q == OP_MUL) begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      // a zero divisor naturally yields an all-ones quotient and remainder == dividend
      acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], div_ge};
    end
    fin_res_d = (op_q == OP_REMU) ? acc_d : lo_d;
    fin_hi_d  = (op_q == OP_MUL) ? acc_d : '0;
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            in_rdy_q <= 1'b0;
            op_q     <= ALU_OPERATION;
            b_q      <= B;
            cnt_q    <= '0;
            if (sc_iter_d) begin
              state_q <= S_BUSY;
              acc_q   <= '0;
              lo_q    <= A;
            end else begin
              state_q   <= S_DONE;
              out_vld_q <= 1'b1;
              res_q     <= sc_res_d;
              hi_q      <= '0;
              zero_q    <= (sc_res_d == '0);
              neg_q     <= sc_res_d[WIDTH-1];
              carry_q   <= sc_carry_d;
              ovf_q     <= sc_ovf_d;
              ill_q     <= sc_ill_d;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + SW'(1);
          if (cnt_q == LAST) begin
            state_q   <= S_DONE;
            out_vld_q <= 1'b1;
            res_q     <= fin_res_d;
            hi_q      <= fin_hi_d;
            zero_q    <= (fin_res_d == '0);
            neg_q     <= fin_res_d[WIDTH-1];
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ill_q     <= 1'b0;
          end
        end
        S_DONE: begin
          // no accept on the release edge: IN_READY only rises the cycle after
          if (OUT_READY) begin
            state_q   <= S_IDLE;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          in_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign IN_READY      = in_rdy_q & ~RESET;
  assign OUT_VALID     = out_vld_q;
  assign ALU_RESULT    = res_q;
  assign ALU_RESULT_HI = hi_q;
  assign ZERO          = zero_q;
  assign NEG           = neg_q;
  assign CARRY         = carry_q;
  assign OVERFLOW      = ovf_q;
  assign ILLEGAL       = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus randomized ops against an arithmetic
// reference model; a second instance built without multiply/divide checks illegal decode.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0, in_vld2 = 1'b0;
  logic        out_rdy = 1'b0, out_rdy2 = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [3:0]  op_i = '0, op2 = '0;

  logic        in_rdy, out_vld, zero, neg, carry, ovf, ill;
  logic [31:0] res, res_hi;
  logic        in_rdy2, out_vld2, zero2, neg2, carry2, ovf2, ill2;
  logic [31:0] res2, res_hi2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .CLK(clk), .RESET(rst), .IN_VALID(in_vld), .IN_READY(in_rdy),
    .A(a_i), .B(b_i), .ALU_OPERATION(op_i),
    .OUT_VALID(out_vld), .OUT_READY(out_rdy),
    .ALU_RESULT(res), .ALU_RESULT_HI(res_hi),
    .ZERO(zero), .NEG(neg), .CARRY(carry), .OVERFLOW(ovf), .ILLEGAL(ill)
  );

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b0)) dut_nomd (
    .CLK(clk), .RESET(rst), .IN_VALID(in_vld2), .IN_READY(in_rdy2),
    .A(a_i), .B(b_i), .ALU_OPERATION(op2),
    .OUT_VALID(out_vld2), .OUT_READY(out_rdy2),
    .ALU_RESULT(res2), .ALU_RESULT_HI(res_hi2),
    .ZERO(zero2), .NEG(neg2), .CARRY(carry2), .OVERFLOW(ovf2), .ILLEGAL(ill2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values; flags = {ZERO,NEG,CARRY,OVERFLOW,ILLEGAL}
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit muldiv, output logic [31:0] r, output logic [31:0] h,
                           output logic [4:0] fl, output int lat);
    logic [63:0] u;
    longint      s;
    longint      smax, smin;
    int          sh;
    logic        c, v, il;
    smax = 2147483647;
    smin = -smax - 1;
    sh  = int'(b % 32);
    r = '0; h = '0; c = 0; v = 0; il = 0; lat = 1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd2: begin
        u = {32'd0, a} + {32'd0, b};
        r = u[31:0];
        c = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > smax) || (s < smin);
      end
      4'd6: begin
        r = a - b;
        c = (a < b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > smax) || (s < smin);
      end
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = $signed(a) >>> sh;
      4'd12, 4'd13, 4'd14: begin
        if (!muldiv) begin
          r = '1; il = 1;
        end else begin
          lat = 33;
          if (op == 4'd12) begin
            u = {32'd0, a} * {32'd0, b};
            r = u[31:0];
            h = u[63:32];
          end else if (op == 4'd13) begin
            r = (b == 0) ? 32'hFFFF_FFFF : a / b;
          end else begin
            r = (b == 0) ? a : a % b;
          end
        end
      end
      default: begin r = '1; il = 1; end
    endcase
    fl = {(r == 0), r[31], c, v, il};
  endtask

  // Issue one op to the main instance, check latency/result/flags, hold for `hold` cycles, release
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er, eh;
    logic [4:0]  ef;
    int          elat, lat, w;
    bit          busy_rdy;
    ref_model(op, a, b, 1'b1, er, eh, ef, elat);
    w = 0;
    while (!in_rdy && w < 10) begin @(posedge clk); #1; w++; end
    in_vld = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    in_vld = 1'b0;
    // inputs wander after acceptance; the result must not follow them
    a_i = $urandom; b_i = $urandom; op_i = 4'($urandom_range(0, 15));
    lat = 1; busy_rdy = 0;
    while (!out_vld && lat < 100) begin
      if (in_rdy) busy_rdy = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("lat op%0d", op), 64'(lat), 64'(elat));
    chk($sformatf("rdy_busy op%0d", op), 64'(busy_rdy), 64'd0);
    chk($sformatf("res op%0d a=%h b=%h", op, a, b), 64'(res), 64'(er));
    chk($sformatf("hi op%0d", op), 64'(res_hi), 64'(eh));
    chk($sformatf("flags op%0d", op), 64'({zero, neg, carry, ovf, ill}), 64'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold vld", 64'(out_vld), 64'd1);
      chk("hold in_rdy", 64'(in_rdy), 64'd0);
      chk("hold res", 64'({res_hi, res}), {eh, er});
      chk("hold flags", 64'({zero, neg, carry, ovf, ill}), 64'(ef));
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk("release vld", 64'(out_vld), 64'd0);
    chk("release in_rdy", 64'(in_rdy), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er, eh;
    logic [4:0]  ef;
    int          elat;
    bit          seen;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset vld", 64'(out_vld), 64'd0);
    chk("reset res", 64'({res_hi, res}), 64'd0);
    chk("reset flags", 64'({zero, neg, carry, ovf, ill}), 64'd0);
    chk("reset in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;

    // directed corners
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b0110, 32'h8000_0000, 32'd1, 0);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(4'b1101, 32'd100, 32'd7, 0);
    do_op(4'b1110, 32'd100, 32'd7, 0);
    do_op(4'b1101, 32'd5, 32'd0, 0);
    do_op(4'b1110, 32'd5, 32'd0, 0);
    do_op(4'b1010, 32'h8000_0000, 32'h24, 0);
    do_op(4'b1111, 32'h1234_5678, 32'h9, 0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b1011, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 5);
    do_op(4'b1100, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5);

    // instance without multiply/divide: MUL opcode is illegal with single-cycle timing
    in_vld2 = 1'b1; op2 = 4'b1100; a_i = 32'd3; b_i = 32'd4;
    @(posedge clk); #1;
    in_vld2 = 1'b0;
    ref_model(4'b1100, 32'd3, 32'd4, 1'b0, er, eh, ef, elat);
    chk("nomd vld", 64'(out_vld2), 64'(elat == 1));
    chk("nomd res", 64'(res2), 64'(er));
    chk("nomd flags", 64'({zero2, neg2, carry2, ovf2, ill2}), 64'(ef));
    out_rdy2 = 1'b1;
    @(posedge clk); #1;
    out_rdy2 = 1'b0;
    chk("nomd release", 64'({out_vld2, in_rdy2}), 64'b01);

    // reset 10 cycles into a MUL aborts it
    in_vld = 1'b1; op_i = 4'b1100; a_i = 32'h1234; b_i = 32'h5678;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort vld", 64'(out_vld), 64'd0);
    chk("abort res", 64'({res_hi, res}), 64'd0);
    chk("abort flags", 64'({zero, neg, carry, ovf, ill}), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort in_rdy", 64'(in_rdy), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_vld) seen = 1;
    end
    chk("abort no output", 64'(seen), 64'd0);

    // randomized ops
    for (int n = 0; n < 150; n++) begin
      do_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor to the combinational datapath ALU.
- Adds registered outputs, valid/ready handshakes, status flags, shifts and compare, and an iterative multiply/divide unit.
- Sits between the decode/operand-fetch stage and writeback; one transaction in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, at least 4.
- MULDIV_EN, 1, 1 = multiply/divide opcodes implemented; 0 = those opcodes are illegal.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operands and opcode are valid.
- IN_READY  output  1  block can accept a transaction.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_OPERATION  input  4  opcode.
- OUT_VALID  output  1  result and flags are valid.
- OUT_READY  input  1  consumer accepts the result.
- ALU_RESULT  output  WIDTH  result.
- ALU_RESULT_HI  output  WIDTH  MUL upper half; 0 for all other operations.
- ZERO  output  1  ALU_RESULT == 0.
- NEG  output  1  ALU_RESULT[WIDTH-1].
- CARRY  output  1  ADD carry-out or SUB borrow; 0 otherwise.
- OVERFLOW  output  1  signed overflow for ADD/SUB; 0 otherwise.
- ILLEGAL  output  1  opcode was unsupported.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (unchanged encodings).
  - 0011 XOR.
  - 0111 SLT: signed, result 1 or 0.
  - 1011 SLTU: unsigned, result 1 or 0.
  - 1000 SLL, 1001 SRL, 1010 SRA. Shift amount is B[log2(WIDTH)-1:0]; upper B bits are ignored.
  - 1100 MUL: unsigned product; low half to ALU_RESULT, high half to ALU_RESULT_HI.
  - 1101 DIVU, 1110 REMU.
- Any other opcode, or 1100–1110 with MULDIV_EN=0:
  - ALU_RESULT = all ones, ILLEGAL = 1, single-cycle timing.
  - ZERO/NEG computed from the result; CARRY/OVERFLOW = 0.
- States: IDLE, BUSY, DONE.
- IN_READY = 1 only in IDLE. A transfer occurs on a rising edge with IN_VALID && IN_READY. A, B and the opcode are latched then; later input changes are ignored.
- Single-cycle ops (everything except MUL/DIVU/REMU):
  - IDLE -> DONE on the accepting edge.
  - Result is registered; OUT_VALID = 1 in the cycle right after acceptance (latency 1).
- MUL/DIVU/REMU: IDLE -> BUSY on the accepting edge.
  - MUL is shift-add, one bit per cycle.
  - DIVU/REMU use restoring division, one bit per cycle.
  - A cycle counter runs WIDTH iterations. BUSY -> DONE on the WIDTH-th BUSY edge, so OUT_VALID rises WIDTH+1 cycles after acceptance.
- DONE:
  - OUT_VALID = 1; result and all flags are held stable until OUT_READY = 1 is sampled.
  - DONE -> IDLE on the edge where OUT_READY = 1. OUT_VALID drops and IN_READY rises the following cycle.
  - No same-edge accept in DONE; maximum throughput is one op per 2 cycles.
- Divide by zero: DIVU result = all ones, REMU result = A. Full WIDTH latency, ILLEGAL = 0.
- Flags:
  - CARRY (ADD) = bit WIDTH of A+B.
  - CARRY (SUB) = 1 when A < B unsigned.
  - OVERFLOW (ADD) = sign(A) == sign(B) && sign(result) != sign(A).
  - OVERFLOW (SUB) = sign(A) != sign(B) && sign(result) != sign(A).
- Reset (asynchronous):
  - State -> IDLE; counter and internal registers cleared.
  - OUT_VALID = 0; ALU_RESULT, ALU_RESULT_HI and all flags = 0; IN_READY = 1 once RESET deasserts.
  - Reset during BUSY or DONE aborts the transaction; no OUT_VALID is produced for it.
- Undriven or X opcodes are never accepted: IN_VALID must be 0 or 1 when sampled.

Test Plan:
- ADD, A=0xFFFFFFFF, B=1 -> OUT_VALID after 1 cycle; ALU_RESULT=0, ZERO=1, CARRY=1, OVERFLOW=0.
- SUB, A=0x80000000, B=1 -> ALU_RESULT=0x7FFFFFFF, OVERFLOW=1, CARRY=0, NEG=0.
- MUL, A=0xFFFFFFFF, B=2 -> OUT_VALID exactly 33 cycles after acceptance; ALU_RESULT=0xFFFFFFFE, ALU_RESULT_HI=1. IN_READY=0 throughout BUSY, and A/B changed mid-op do not affect the result.
- DIVU, A=100, B=7 -> 14; REMU, A=100, B=7 -> 2. DIVU, A=5, B=0 -> 0xFFFFFFFF; REMU, A=5, B=0 -> 5.
- SRA, A=0x80000000, B=0x24 -> shift 4, result 0xF8000000; opcode 1111 -> 0xFFFFFFFF, ILLEGAL=1. MULDIV_EN=0 instance with opcode 1100 -> ILLEGAL=1 after 1 cycle.
- Backpressure and reset:
  - OUT_READY held 0 for 5 cycles in DONE -> outputs stable, IN_READY=0.
  - Assert RESET 10 cycles into a MUL -> OUT_VALID=0 and all outputs 0 immediately; IN_READY=1 after release.
